ula_lo_seq: RTL
===============

Name: ula_lo_seq

Overview:
- Parametrised successor to the logic-only ALU. Same 5-bit opcode set for bitwise ops and constants.
- Adds multi-bit logical and arithmetic shifts and rotates, executed iteratively at one bit per cycle.
- Adds registered flags O/C/S/Z and a valid/ready handshake on both input and output.
- Sits beside the arithmetic ALU in the execute stage; the control unit stalls on in_ready/out_valid.

Parameters:
- BITS, 16, operand/result width (≥4).
- SHW, $clog2(BITS), width of shift-amount field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request (high only in IDLE)
- A  in  BITS  operand A (signed)
- B  in  BITS  operand B (signed)
- SH  in  SHW  shift amount (shift/rotate ops only)
- OP  in  5  operation code
- out_valid  out  1  RESU/flags valid
- out_ready  in  1  consumer accepts result
- RESU  out  BITS  result
- O  out  1  overflow flag
- C  out  1  carry flag
- S  out  1  sign flag
- Z  out  1  zero flag

Behaviour:
- Reset (sync, active-high, priority over everything, including mid-shift): state=IDLE, in_ready=1, out_valid=0, RESU=0, O=C=S=Z=0, internal shift count=0.
- Accept: in_valid & in_ready at a rising edge latches A, B, SH and OP.
- States and transitions:
  - IDLE → EXEC on accept of a non-shift op.
  - IDLE → SHIFT on accept of a shift op with SH≠0.
  - IDLE → EXEC on accept of a shift op with SH=0.
  - SHIFT: one bit position per cycle; count decrements; SHIFT → EXEC when count reaches 1 after that cycle's step.
  - EXEC: computes flags, loads outputs, → HOLD.
  - HOLD: out_valid=1; RESU/flags stable; → IDLE when out_ready=1.
- Latency: logic op 2 cycles from accept to out_valid; shift op SH+1 cycles (SH=0 → 2 cycles).
- Throughput: one op in flight; in_ready=0 outside IDLE. in_valid while busy is ignored (not queued).
- Shift/rotate opcodes:
  - 01000 LSL: zero fill; C = last bit shifted out of bit BITS-1.
  - 01001 ASR: sign-preserving; C = last bit shifted out of bit 0.
  - 01010 LSR: zero fill; C = last bit shifted out of bit 0.
  - 01011 ROL: C = last bit rotated out of bit BITS-1.
  - 01100 ROR: C = last bit rotated out of bit 0.
- Logic opcodes, unchanged encoding:
  - 10000 → 0
  - 10001 → A&B
  - 10010 → ~A&B
  - 10011 → B
  - 10100 → A&~B
  - 10101 → A
  - 10110 → A^B
  - 10111 → A|B
  - 11000 → ~A&~B
  - 11001 → ~(A^B)
  - 11010 → ~A
  - 11011 → ~A|B
  - 11100 → ~B
  - 11101 → A|~B
  - 11110 → ~A|~B
  - 11111 → 1
- Undefined OP: RESU=0, all flags 0, normal 2-cycle completion, no error.
- Flags, computed in EXEC:
  - O=1 only for LSL when any shift step changed bit BITS-1; else 0.
  - C=0 for all non-shift ops and for SH=0.
  - Z = (RESU==0); S = RESU[BITS-1].
  - Exceptions: OP 10011 and 11111 force Z=S=0; OP 10000 forces S=0 (Z=1).
- SH is taken modulo BITS by width; no saturation.
- Simultaneous out_ready and in_valid in HOLD: result retires and the unit returns to IDLE. The new request is accepted the following cycle, not the same one.

Decomposition:
- Package ula_pkg: op_e enum of all 5-bit opcodes; state_e {IDLE, SHIFT, EXEC, HOLD}; function is_shift_op(op).
- Sub-module ula_lo_shift1: combinational single-step shifter (op, value in) → (value out, bit out). Instantiated once and used iteratively.

Test Plan:
- Reset mid-shift: ASR by 10 started, reset asserted in 4th SHIFT cycle → next edge in_ready=1, out_valid=0, RESU=0, all flags 0.
- LSL, BITS=16, A=16'h4001, SH=2 → out_valid 3 cycles after accept; RESU=16'h0004, C=1, O=1, S=0, Z=0.
- ASR, A=16'h8003, SH=1 → RESU=16'hC001, C=1, S=1, Z=0, O=0; ROR by 4 of 16'h1234 → RESU=16'h4123, C=0.
- A^B (10110), A=B=16'h5A5A → out_valid 2 cycles after accept; RESU=0, Z=1, S=0, C=0. Same op with out_ready held low 5 cycles → outputs stable, in_ready=0 throughout.
- OP=10011, B=0 → RESU=0, Z=0, S=0. OP=10000 → Z=1, S=0. OP=00111 (undefined) → RESU=0, flags 0.
- Back-to-back: in_valid held high with two queued requests → second accepted exactly one cycle after first HOLD handshake; no request lost or duplicated.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared types for the sequential logic/shift ALU.
//   op_e        - every 5-bit opcode the unit decodes (other codes are undefined)
//   state_e     - control FSM states
//   is_shift_op - true for the iterative shift/rotate opcodes
package ula_pkg;

    typedef enum logic [4:0] {
        OP_LSL    = 5'b01000,
        OP_ASR    = 5'b01001,
        OP_LSR    = 5'b01010,
        OP_ROL    = 5'b01011,
        OP_ROR    = 5'b01100,
        OP_ZERO   = 5'b10000,
        OP_AND    = 5'b10001,
        OP_NA_B   = 5'b10010,
        OP_B      = 5'b10011,
        OP_A_NB   = 5'b10100,
        OP_A      = 5'b10101,
        OP_XOR    = 5'b10110,
        OP_OR     = 5'b10111,
        OP_NOR    = 5'b11000,
        OP_XNOR   = 5'b11001,
        OP_NA     = 5'b11010,
        OP_NA_OR  = 5'b11011,
        OP_NB     = 5'b11100,
        OP_A_ORNB = 5'b11101,
        OP_NAND   = 5'b11110,
        OP_ONE    = 5'b11111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EXEC,
        HOLD
    } state_e;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == OP_LSL) || (op == OP_ASR) || (op == OP_LSR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/ula_lo_shift1.sv
// ula_lo_shift1: combinational single-position shifter/rotator.
//   op   - shift opcode selecting LSL/ASR/LSR/ROL/ROR
//   din  - value before the step
//   dout - value after one bit position of shift/rotate
//   bout - bit that left the word (or wrapped around) during this step
module ula_lo_shift1
    import ula_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic [4:0]      op,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout,
    output logic            bout
);

    always_comb begin
        dout = din;
        bout = 1'b0;
        case (op)
            OP_LSL: begin
                dout = {din[BITS-2:0], 1'b0};
                bout = din[BITS-1];
            end
            OP_ASR: begin
                dout = {din[BITS-1], din[BITS-1:1]};
                bout = din[0];
            end
            OP_LSR: begin
                dout = {1'b0, din[BITS-1:1]};
                bout = din[0];
            end
            OP_ROL: begin
                dout = {din[BITS-2:0], din[BITS-1]};
                bout = din[BITS-1];
            end
            OP_ROR: begin
                dout = {din[0], din[BITS-1:1]};
                bout = din[0];
            end
            default: begin
                dout = din;
                bout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_lo_seq.sv
// ula_lo_seq: sequential logic ALU with iterative shifts/rotates and O/C/S/Z flags.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake (in_ready high only when idle)
//   A, B, SH, OP        - operands, shift amount, opcode (latched on accept)
//   out_valid/out_ready - result handshake; RESU and flags hold until retired
//   RESU, O, C, S, Z    - result and overflow/carry/sign/zero flags
module ula_lo_seq
    import ula_pkg::*;
#(
    parameter int BITS = 16,
    parameter int SHW  = $clog2(BITS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic [SHW-1:0]  SH,
    input  logic [4:0]      OP,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] RESU,
    output logic            O,
    output logic            C,
    output logic            S,
    output logic            Z
);

    state_e          state_q, state_d;
    op_e             op_q;
    logic [BITS-1:0] a_q, b_q;
    logic [SHW-1:0]  cnt_q;
    logic            ovf_q, cout_q;

    logic [BITS-1:0] resu_q;
    logic            o_q, c_q, s_q, z_q;

    logic [BITS-1:0] step_val;
    logic            step_bit;
    logic            step_msb_chg;

    logic [BITS-1:0] exec_res;
    logic            exec_o, exec_c, exec_s, exec_z;
    logic            exec_known;

    // a_q doubles as the shift working register; the step always acts on it.
    ula_lo_shift1 #(.BITS(BITS)) u_step (
        .op   (op_q),
        .din  (a_q),
        .dout (step_val),
        .bout (step_bit)
    );

    assign step_msb_chg = (op_q == OP_LSL) && (step_val[BITS-1] != a_q[BITS-1]);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign RESU      = resu_q;
    assign O         = o_q;
    assign C         = c_q;
    assign S         = s_q;
    assign Z         = z_q;

    // SHIFT performs SH-1 steps and EXEC performs the last one, so a shift
    // costs SH+1 cycles including the accept cycle. SH=1 therefore needs no
    // SHIFT cycle and goes straight to EXEC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift_op(OP) && (SH > SHW'(1))) state_d = SHIFT;
                    else                                   state_d = EXEC;
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(2)) state_d = EXEC;
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exec_res   = '0;
        exec_o     = 1'b0;
        exec_c     = 1'b0;
        exec_s     = 1'b0;
        exec_z     = 1'b0;
        exec_known = 1'b1;
        if (is_shift_op(op_q)) begin
            exec_res = a_q;
            exec_c   = cout_q;
            exec_o   = ovf_q;
            if (cnt_q != '0) begin
                exec_res = step_val;
                exec_c   = step_bit;
                exec_o   = ovf_q | step_msb_chg;
            end
            exec_z = (exec_res == '0);
            exec_s = exec_res[BITS-1];
        end else begin
            case (op_q)
                OP_ZERO:   exec_res = '0;
                OP_AND:    exec_res = a_q & b_q;
                OP_NA_B:   exec_res = ~a_q & b_q;
                OP_B:      exec_res = b_q;
                OP_A_NB:   exec_res = a_q & ~b_q;
                OP_A:      exec_res = a_q;
                OP_XOR:    exec_res = a_q ^ b_q;
                OP_OR:     exec_res = a_q | b_q;
                OP_NOR:    exec_res = ~a_q & ~b_q;
                OP_XNOR:   exec_res = ~(a_q ^ b_q);
                OP_NA:     exec_res = ~a_q;
                OP_NA_OR:  exec_res = ~a_q | b_q;
                OP_NB:     exec_res = ~b_q;
                OP_A_ORNB: exec_res = a_q | ~b_q;
                OP_NAND:   exec_res = ~a_q | ~b_q;
                OP_ONE:    exec_res = '1;
                default: begin
                    exec_res   = '0;
                    exec_known = 1'b0;
                end
            endcase
            if (exec_known) begin
                exec_z = (exec_res == '0);
                exec_s = exec_res[BITS-1];
            end
            // Pass-through B and the all-ones constant never report Z or S.
            if (op_q == OP_B || op_q == OP_ONE) begin
                exec_z = 1'b0;
                exec_s = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_ZERO;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            resu_q  <= '0;
            o_q     <= 1'b0;
            c_q     <= 1'b0;
            s_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op_e'(OP);
                        a_q    <= A;
                        b_q    <= B;
                        cnt_q  <= SH;
                        ovf_q  <= 1'b0;
                        cout_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_q    <= step_val;
                    cout_q <= step_bit;
                    ovf_q  <= ovf_q | step_msb_chg;
                    cnt_q  <= cnt_q - SHW'(1);
                end
                EXEC: begin
                    resu_q <= exec_res;
                    o_q    <= exec_o;
                    c_q    <= exec_c;
                    s_q    <= exec_s;
                    z_q    <= exec_z;
                    cnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
